// File: rtl/mem_acc_pkg.sv
// Shared types and constants for the memory access controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, grant owner encoding, wait-count sizing.
package mem_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Grant owner encoding; also the bit index of each requester in req/mask vectors.
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_IO  = 1'b1;

    localparam int WAIT_MAX = 15;
    localparam int WCNT_W   = 4;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of requester (cpu/io) handshakes and the single-port memory bus.
// Latency: n/a (wiring only).
// Backpressure: req is a level held until the matching one-cycle ack.
//
// Modports:
//   slave  - controller view: takes requests, drives acks and the memory bus.
//   master - requester/memory view: the mirror image.
interface mem_access_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          io_req;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata;
    logic          io_ack;
    logic [DW-1:0] io_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          grant_io;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  io_req, io_we, io_addr, io_wdata,
        output io_ack, io_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, grant_io
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output io_req, io_we, io_addr, io_wdata,
        input  io_ack, io_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, grant_io
    );

endinterface

// File: rtl/mac_rr_arb.sv
// Two-input round-robin arbiter (cpu = bit 0, io = bit 1) with a per-requester mask.
// Latency: combinational grant; last_grant updates on the edge a grant is taken.
// Backpressure: a grant is only consumed when take = 1; otherwise nothing changes.
//
// Ports: clk, rst (async, active-high), req[1:0], mask[1:0], take,
//        gnt_vld (some eligible requester), gnt_id (GNT_CPU / GNT_IO).
module mac_rr_arb
    import mem_acc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       take,
    output logic       gnt_vld,
    output logic       gnt_id
);

    logic       last_grant;
    logic [1:0] elig;

    always_comb begin
        elig    = req & ~mask;
        gnt_vld = |elig;
        gnt_id  = GNT_CPU;
        if (&elig) begin
            // Tie: hand the slot to whoever did not have it last time.
            gnt_id = (last_grant == GNT_IO) ? GNT_CPU : GNT_IO;
        end else if (elig[1]) begin
            gnt_id = GNT_IO;
        end
    end

    // Reset to IO so the CPU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_IO;
        end else if (take && gnt_vld) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares one synchronous single-port memory between a CPU and an I/O requester.
// Latency: request seen in IDLE at cycle 0 -> ack in cycle WAIT+3; one access per WAIT+4 cycles.
// Backpressure: req is held until ack; only one transaction is ever outstanding.
//
// Ports: clk, reset (async, active-high), bus (mem_access_ctrl_if.slave: cpu_*, io_*, mem_*,
//        busy, grant_io). Parameters AW, DW, WAIT (0..15 extra mem_en cycles).
// Build option: define MEM_ACC_IO_PORT_EN to enable the I/O requester and round-robin arbiter;
//        without it io_req is ignored and io_ack / io_rdata / grant_io are held at 0.
module mem_access_ctrl
    import mem_acc_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int WAIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_ctrl_if.slave   bus
);

    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT);

    state_t            state;
    state_t            state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [DW-1:0]     rdata_q;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic              gnt_q;        // owner of the current / most recent transaction
    logic [1:0]        served_mask;  // blocks the just-served requester for one IDLE cycle
    logic              gnt_vld;
    logic              gnt_id;

`ifdef MEM_ACC_IO_PORT_EN
    mac_rr_arb u_arb (
        .clk     (clk),
        .rst     (reset),
        .req     ({bus.io_req, bus.cpu_req}),
        .mask    (served_mask),
        .take    (state == ST_IDLE),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );
`else
    // Single requester: no arbitration, only the post-ack mask applies.
    assign gnt_vld = bus.cpu_req && !served_mask[0];
    assign gnt_id  = GNT_CPU;

    logic io_unused;
    assign io_unused = bus.io_req ^ served_mask[1];
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (gnt_vld) state_nxt = ST_ACCESS;
            ST_ACCESS:  if (wcnt == WAIT_LAST) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath / bookkeeping registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt        <= '0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt_q       <= GNT_CPU;
            served_mask <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    served_mask <= 2'b00;
                    if (gnt_vld) begin
                        // Requester inputs are only looked at on this edge.
                        gnt_q <= gnt_id;
                        if (gnt_id == GNT_IO) begin
                            we_q    <= bus.io_we;
                            addr_q  <= bus.io_addr;
                            wdata_q <= bus.io_wdata;
                        end else begin
                            we_q    <= bus.cpu_we;
                            addr_q  <= bus.cpu_addr;
                            wdata_q <= bus.cpu_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    wcnt <= (wcnt == WAIT_LAST) ? '0 : wcnt + WCNT_W'(1);
                end
                ST_CAPTURE: begin
                    // Loaded for writes too; the value is simply not meaningful then.
                    rdata_q <= bus.mem_rdata;
                end
                ST_DONE: begin
                    // Requester may still show req in the following IDLE cycle.
                    served_mask <= (gnt_q == GNT_IO) ? 2'b10 : 2'b01;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.mem_en  = 1'b0;
        bus.mem_we  = 1'b0;
        bus.busy    = 1'b1;
        bus.cpu_ack = 1'b0;
        bus.io_ack  = 1'b0;
        case (state)
            ST_IDLE: bus.busy = 1'b0;
            ST_ACCESS: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_q;
            end
            ST_DONE: begin
                bus.cpu_ack = (gnt_q == GNT_CPU);
`ifdef MEM_ACC_IO_PORT_EN
                bus.io_ack  = (gnt_q == GNT_IO);
`endif
            end
            default: ;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = (gnt_q == GNT_CPU) ? rdata_q : '0;

`ifdef MEM_ACC_IO_PORT_EN
    assign bus.io_rdata  = (gnt_q == GNT_IO) ? rdata_q : '0;
    assign bus.grant_io  = gnt_q;
`else
    assign bus.io_rdata  = '0;
    assign bus.grant_io  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed steps followed by randomized traffic.
// Latency: expectations follow the request->ack timeline of WAIT+3 cycles, slot of WAIT+4.
// Backpressure: requesters hold req until ack, sometimes an extra cycle, sometimes drop early.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int WAIT = 1;
`ifdef MEM_ACC_IO_PORT_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.AW(AW), .DW(DW)) ifc ();

    mem_access_ctrl #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // ---------------- memory environment ----------------
    logic [7:0] mem_arr [256];

    function automatic logic [7:0] mem_init_val(input int i);
        return (i == 16) ? 8'hA5 : 8'(i * 29 + 7);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= mem_init_val(i);
        end else if (ifc.mem_en) begin
            if (ifc.mem_we) mem_arr[ifc.mem_addr] <= ifc.mem_wdata;
            ifc.mem_rdata <= mem_arr[ifc.mem_addr];
        end
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // ---------------- reference model (transaction timeline) ----------------
    logic [7:0] ref_mem [256];
    int   free_at;          // first cycle the controller is back in IDLE
    bit   has_txn;
    int   g_cyc;            // cycle the current transaction was granted
    bit   owner;            // 0 = cpu, 1 = io
    bit   last;             // owner of the most recent grant
    bit   mask_vld;
    bit   mask_id;
    bit   m_we;
    logic [7:0] m_addr, m_wdata, m_exp_rd;

    task automatic model_reset();
        has_txn  = 1'b0;
        free_at  = 0;
        last     = 1'b1;
        mask_vld = 1'b0;
        mask_id  = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_init_val(i);
    endtask

    // Decide what the controller does with the inputs present in cycle 'cyc'.
    task automatic arbitrate();
        bit e_c, e_i, w;
        if (cyc >= free_at) begin
            e_c = (ifc.cpu_req === 1'b1) && !(mask_vld && !mask_id && cyc == free_at);
            e_i = IO_EN && (ifc.io_req === 1'b1) && !(mask_vld && mask_id && cyc == free_at);
            if (e_c || e_i) begin
                w        = (e_c && e_i) ? !last : e_i;
                last     = w;
                owner    = w;
                has_txn  = 1'b1;
                g_cyc    = cyc;
                free_at  = cyc + WAIT + 4;
                mask_vld = 1'b1;
                mask_id  = w;
                m_we     = w ? ifc.io_we    : ifc.cpu_we;
                m_addr   = w ? ifc.io_addr  : ifc.cpu_addr;
                m_wdata  = w ? ifc.io_wdata : ifc.cpu_wdata;
                m_exp_rd = ref_mem[m_addr];
                if (m_we) ref_mem[m_addr] = m_wdata;
                drv_st[w] = 2;
            end
        end
    endtask

    // ---------------- ack recording ----------------
    bit recording = 1'b0;
    int ack_c[$];
    bit ack_o[$];

    task automatic check_outputs();
        bit in_acc, e_busy, e_ack;
        in_acc = has_txn && cyc >= g_cyc + 1 && cyc <= g_cyc + WAIT + 1;
        e_busy = has_txn && cyc > g_cyc && cyc < free_at;
        e_ack  = has_txn && cyc == g_cyc + WAIT + 3;
        chk("busy",     32'(ifc.busy),     32'(e_busy));
        chk("mem_en",   32'(ifc.mem_en),   32'(in_acc));
        chk("mem_we",   32'(ifc.mem_we),   32'(in_acc && m_we));
        if (in_acc) begin
            chk("mem_addr", 32'(ifc.mem_addr), 32'(m_addr));
            if (m_we) chk("mem_wdata", 32'(ifc.mem_wdata), 32'(m_wdata));
        end
        chk("cpu_ack",  32'(ifc.cpu_ack),  32'(e_ack && !owner));
        chk("io_ack",   32'(ifc.io_ack),   32'(e_ack && owner));
        chk("grant_io", 32'(ifc.grant_io), 32'(has_txn && owner));
        if (e_ack && !m_we)
            chk(owner ? "io_rdata" : "cpu_rdata",
                32'(owner ? ifc.io_rdata : ifc.cpu_rdata), 32'(m_exp_rd));
        if (has_txn) begin
            chk("other_rdata_zero", 32'(owner ? ifc.cpu_rdata : ifc.io_rdata), 32'(0));
        end else begin
            chk("cpu_rdata_zero", 32'(ifc.cpu_rdata), 32'(0));
            chk("io_rdata_zero",  32'(ifc.io_rdata),  32'(0));
        end
        if (recording && (ifc.cpu_ack === 1'b1 || ifc.io_ack === 1'b1)) begin
            ack_c.push_back(cyc);
            ack_o.push_back(ifc.io_ack === 1'b1);
        end
    endtask

    // ---------------- random requesters ----------------
    int drv_st[2];          // 0 gap, 1 requesting, 2 granted, 3 post-ack hold
    int drv_gap[2];
    bit saturate = 1'b0;
    bit auto_drv = 1'b0;

    task automatic set_req(input int r, input bit rq, input bit we,
                           input logic [7:0] a, input logic [7:0] d);
        if (r == 0) begin
            ifc.cpu_req = rq; ifc.cpu_we = we; ifc.cpu_addr = a; ifc.cpu_wdata = d;
        end else begin
            ifc.io_req = rq;  ifc.io_we = we;  ifc.io_addr = a;  ifc.io_wdata = d;
        end
    endtask

    task automatic new_txn(input int r);
        set_req(r, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
        drv_st[r] = 1;
    endtask

    task automatic go_idle(input int r);
        set_req(r, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        drv_gap[r] = $urandom_range(0, 4);
        drv_st[r]  = 0;
    endtask

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            bit cur;
            cur = (r == 0) ? ifc.cpu_req : ifc.io_req;
            case (drv_st[r])
                0: begin
                    if (drv_gap[r] == 0) new_txn(r);
                    else begin
                        drv_gap[r]--;
                        set_req(r, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                    end
                end
                2: begin
                    if (cyc == g_cyc + WAIT + 4) begin
                        // Cycle after ack: keep req up one more cycle, or drop it.
                        if (saturate || (cur && $urandom_range(0, 1) == 1)) drv_st[r] = 3;
                        else go_idle(r);
                    end else if (cur && !saturate && $urandom_range(0, 15) == 0) begin
                        set_req(r, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                    end else if (cur && $urandom_range(0, 3) == 0) begin
                        set_req(r, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                    end
                end
                3: begin
                    if (saturate) new_txn(r);
                    else go_idle(r);
                end
                default: ;
            endcase
        end
    endtask

    // One clock: settle this cycle's decision, advance, check the new cycle.
    task automatic step();
        arbitrate();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (auto_drv) drive();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        model_reset();
        drv_st  = '{0, 0};
        drv_gap = '{0, 0};
        repeat (2) @(posedge clk);
        #1;

        // Reset state: every output low.
        chk("rst_cpu_ack",   32'(ifc.cpu_ack),   32'(0));
        chk("rst_io_ack",    32'(ifc.io_ack),    32'(0));
        chk("rst_cpu_rdata", 32'(ifc.cpu_rdata), 32'(0));
        chk("rst_io_rdata",  32'(ifc.io_rdata),  32'(0));
        chk("rst_mem_en",    32'(ifc.mem_en),    32'(0));
        chk("rst_mem_we",    32'(ifc.mem_we),    32'(0));
        chk("rst_mem_addr",  32'(ifc.mem_addr),  32'(0));
        chk("rst_mem_wdata", 32'(ifc.mem_wdata), 32'(0));
        chk("rst_busy",      32'(ifc.busy),      32'(0));
        chk("rst_grant_io",  32'(ifc.grant_io),  32'(0));
        @(negedge clk);
        reset = 1'b0;
        step();

        // CPU read of 0x10 (holds 0xA5); req kept one extra cycle after ack.
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h77);
        for (int t = 1; t <= 7; t++) begin
            step();
            chk("rd_mem_en",  32'(ifc.mem_en),  32'(t == 1 || t == 2));
            chk("rd_cpu_ack", 32'(ifc.cpu_ack), 32'(t == 4));
            if (t == 4) chk("rd_cpu_rdata", 32'(ifc.cpu_rdata), 32'(8'hA5));
            if (t == 6) chk("rd_no_regrant", 32'(ifc.busy), 32'(0));
            if (t == 5) ifc.cpu_req = 1'b0;
        end

        // CPU write 0x3C to 0x20; inputs changed right after the grant edge.
        set_req(0, 1'b1, 1'b1, 8'h20, 8'h3C);
        for (int t = 1; t <= 6; t++) begin
            step();
            if (t == 1) begin
                ifc.cpu_wdata = 8'hFF;
                ifc.cpu_addr  = 8'h55;
            end
            chk("wr_mem_we",  32'(ifc.mem_we),  32'(t == 1 || t == 2));
            chk("wr_cpu_ack", 32'(ifc.cpu_ack), 32'(t == 4));
            if (t == 4) ifc.cpu_req = 1'b0;
        end
        chk("wr_mem_20", 32'(mem_arr[8'h20]), 32'(8'h3C));
        chk("wr_mem_55", 32'(mem_arr[8'h55]), 32'(ref_mem[8'h55]));

        // Reset asserted in the second ACCESS cycle of a read.
        set_req(0, 1'b1, 1'b0, 8'h07, 8'h00);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("midrst_mem_en",  32'(ifc.mem_en),  32'(0));
        chk("midrst_busy",    32'(ifc.busy),    32'(0));
        chk("midrst_cpu_ack", 32'(ifc.cpu_ack), 32'(0));
        chk("midrst_io_ack",  32'(ifc.io_ack),  32'(0));
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First tie after reset goes to the CPU, then the I/O side (if present).
        set_req(0, 1'b1, 1'b0, 8'h03, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h04, 8'h00);
        for (int t = 1; t <= 9; t++) begin
            step();
            if (t == 4) begin
                chk("tie_cpu_first", 32'(ifc.cpu_ack), 32'(1));
                chk("tie_io_later",  32'(ifc.io_ack),  32'(0));
                ifc.cpu_req = 1'b0;
            end
            if (t == 9) begin
                chk("tie_io_second", 32'(ifc.io_ack), 32'(IO_EN));
                ifc.io_req = 1'b0;
            end
        end
        repeat (6) step();

        // Both requesters saturated: ack spacing and alternation.
        drv_st    = '{0, 0};
        drv_gap   = '{0, 0};
        saturate  = 1'b1;
        auto_drv  = 1'b1;
        recording = 1'b1;
        repeat (60) step();
        recording = 1'b0;
        chk("sat_ack_count", 32'(ack_c.size() >= 8), 32'(1));
        for (int i = 1; i < ack_c.size(); i++) begin
            chk("sat_spacing", 32'(ack_c[i] - ack_c[i-1]), 32'(IO_EN ? WAIT + 4 : WAIT + 5));
            if (IO_EN) chk("sat_alternate", 32'(ack_o[i]), 32'(!ack_o[i-1]));
        end

        // Random traffic, including early drops, held reqs and post-grant input churn.
        saturate = 1'b0;
        repeat (2000) step();

        auto_drv = 1'b0;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (10) step();
        chk("end_idle", 32'(ifc.busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
